// File: rtl/wb_pkg.sv
// Shared types for the writeback stage.
// Load sizes and the upstream payload bundle.
package wb_pkg;

  localparam int XLEN    = 64;
  localparam int RADDR_W = 5;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } load_size_t;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic               rd_we;
    logic               is_load;
    load_size_t         size;
    logic               is_unsigned;
    logic [2:0]         addr_lo;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    mem_rdata;
  } wb_req_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension.
// Also reports natural-alignment violations.
module load_align
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      addr_lo,
  input  load_size_t      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [XLEN-1:0] sh;
  logic            sx;

  assign sh = rdata >> {addr_lo, 3'b000};
  assign sx = !is_unsigned;

  always_comb begin
    data       = sh;
    misaligned = 1'b0;
    unique case (size)
      SZ_B: begin
        data = {{56{sx & sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        data       = {{48{sx & sh[15]}}, sh[15:0]};
        misaligned = addr_lo[0];
      end
      SZ_W: begin
        data       = {{32{sx & sh[31]}}, sh[31:0]};
        misaligned = |addr_lo[1:0];
      end
      SZ_D: begin
        data       = sh;
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-entry pipeline register
// driving the register-file write port.
module wb_stage #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_rd_we,
  input  logic               in_is_load,
  input  logic [1:0]         in_size,
  input  logic               in_unsigned,
  input  logic [2:0]         in_addr_lo,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_mem_rdata,
  input  logic               halt,
  input  logic               flush,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output logic               misalign_err,
  output logic [CNT_W-1:0]   instret
);

  import wb_pkg::*;

  wb_req_t          req_d;
  wb_req_t          req_q;
  logic             valid_q;
  logic [CNT_W-1:0] instret_q;
  logic             commit;
  logic             mis_raw;
  logic             mis;
  logic [XLEN-1:0]  ld_data;
  logic [XLEN-1:0]  result;

  always_comb begin
    req_d             = '0;
    req_d.rd          = in_rd;
    req_d.rd_we       = in_rd_we;
    req_d.is_load     = in_is_load;
    req_d.size        = load_size_t'(in_size);
    req_d.is_unsigned = in_unsigned;
    req_d.addr_lo     = in_addr_lo;
    req_d.alu_result  = in_alu_result;
    req_d.mem_rdata   = in_mem_rdata;
  end

  assign in_ready = !valid_q || !halt;
  assign commit   = valid_q && !halt && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      req_q   <= req_d;
    end else if (!(valid_q && halt)) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (commit) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  load_align u_align (
    .rdata       (req_q.mem_rdata),
    .addr_lo     (req_q.addr_lo),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .data        (ld_data),
    .misaligned  (mis_raw)
  );

  assign mis    = req_q.is_load && mis_raw;
  assign result = req_q.is_load ? ld_data : req_q.alu_result;

  assign rf_we = commit && req_q.rd_we
              && (req_q.rd != '0) && !mis;
  assign rf_rd    = req_q.rd;
  assign rf_wdata = result;

  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_rd;
  assign fwd_data  = rf_wdata;

  assign misalign_err = commit && mis;
  assign instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed plan items plus
// randomized traffic against a behavioural model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        in_is_load;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [2:0]  in_addr_lo;
  logic [63:0] in_alu_result;
  logic [63:0] in_mem_rdata;
  logic        halt;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        misalign_err;
  logic [63:0] instret;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(64), .RADDR_W(5), .CNT_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_rd_we     (in_rd_we),
    .in_is_load   (in_is_load),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_addr_lo   (in_addr_lo),
    .in_alu_result(in_alu_result),
    .in_mem_rdata (in_mem_rdata),
    .halt         (halt),
    .flush        (flush),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .misalign_err (misalign_err),
    .instret      (instret)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: the held instruction and retire count
  bit          m_valid;
  logic [4:0]  m_rd;
  bit          m_we;
  bit          m_ld;
  int          m_sz;
  bit          m_uns;
  int          m_addr;
  logic [63:0] m_alu;
  logic [63:0] m_mem;
  logic [63:0] m_cnt;

  function automatic logic [63:0] mload(logic [63:0] d, int a,
                                        int sz, bit u);
    logic [63:0] s;
    logic [63:0] m;
    logic [63:0] v;
    int nb;
    s  = d >> (8 * a);
    nb = 1 << sz;
    m  = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v  = s & m;
    if (!u && nb < 8 && s[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 0; m_rd = '0; m_we = 0; m_ld = 0; m_sz = 0;
      m_uns = 0; m_addr = 0; m_alu = '0; m_mem = '0; m_cnt = '0;
    end else begin
      if (m_valid && !halt && !flush) m_cnt = m_cnt + 64'd1;
      if (flush) m_valid = 0;
      else if (in_valid && (!m_valid || !halt)) begin
        m_valid = 1;
        m_rd = in_rd; m_we = in_rd_we; m_ld = in_is_load;
        m_sz = int'(in_size); m_uns = in_unsigned;
        m_addr = int'(in_addr_lo);
        m_alu = in_alu_result; m_mem = in_mem_rdata;
      end else if (!(m_valid && halt)) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    bit          c;
    bit          mis;
    bit          we;
    logic [63:0] res;
    c   = m_valid && !halt && !flush;
    mis = m_ld && ((m_addr % (1 << m_sz)) != 0);
    we  = c && m_we && (m_rd != 0) && !mis;
    res = m_ld ? mload(m_mem, m_addr, m_sz, m_uns) : m_alu;
    chk("m_in_ready", 64'(in_ready), 64'(!m_valid || !halt));
    chk("m_rf_we", 64'(rf_we), 64'(we));
    chk("m_fwd_valid", 64'(fwd_valid), 64'(we));
    chk("m_rf_rd", 64'(rf_rd), 64'(m_rd));
    chk("m_fwd_rd", 64'(fwd_rd), 64'(m_rd));
    chk("m_rf_wdata", rf_wdata, res);
    chk("m_fwd_data", fwd_data, res);
    chk("m_misalign", 64'(misalign_err), 64'(c && mis));
    chk("m_instret", instret, m_cnt);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rd = '0; in_rd_we = 0; in_is_load = 0;
    in_size = '0; in_unsigned = 0; in_addr_lo = '0;
    in_alu_result = '0; in_mem_rdata = '0;
  endtask

  task automatic send(input logic [4:0] rd, input bit ld,
                      input logic [1:0] sz, input bit u,
                      input logic [2:0] a, input logic [63:0] alu,
                      input logic [63:0] mem);
    in_valid = 1; in_rd = rd; in_rd_we = 1; in_is_load = ld;
    in_size = sz; in_unsigned = u; in_addr_lo = a;
    in_alu_result = alu; in_mem_rdata = mem;
  endtask

  localparam logic [63:0] MEM = 64'h8899AABBCCDDEEFF;

  initial begin
    reset = 0; halt = 0; flush = 0;
    idle();
    cyc(); cyc();
    @(negedge clk);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_rf_rd", 64'(rf_rd), 64'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    cyc();
    reset = 1;
    send(5'd5, 0, 2'd0, 0, 3'd0, 64'h1234, 64'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("alu_we", 64'(rf_we), 64'd1);
    chk("alu_rd", 64'(rf_rd), 64'd5);
    chk("alu_data", rf_wdata, 64'h1234);
    chk("alu_fwd", fwd_data, 64'h1234);
    cyc();
    @(negedge clk);
    chk("alu_instret", instret, 64'd1);
    // Back-to-back loads from one doubleword
    send(5'd6, 1, 2'd0, 0, 3'd1, 64'd0, MEM);
    cyc();
    send(5'd7, 1, 2'd1, 1, 3'd6, 64'd0, MEM);
    @(negedge clk);
    chk("lb", rf_wdata, 64'hFFFF_FFFF_FFFF_FFEE);
    cyc();
    send(5'd8, 1, 2'd2, 0, 3'd4, 64'd0, MEM);
    @(negedge clk);
    chk("lhu", rf_wdata, 64'h8899);
    cyc();
    idle();
    @(negedge clk);
    chk("lw", rf_wdata, 64'hFFFF_FFFF_8899_AABB);
    chk("lw_we", 64'(rf_we), 64'd1);
    cyc();
    @(negedge clk);
    chk("ld_instret", instret, 64'd4);
    send(5'd9, 1, 2'd1, 0, 3'd3, 64'd0, MEM);
    cyc();
    idle();
    @(negedge clk);
    chk("mis_we", 64'(rf_we), 64'd0);
    chk("mis_err", 64'(misalign_err), 64'd1);
    cyc();
    @(negedge clk);
    chk("mis_pulse", 64'(misalign_err), 64'd0);
    chk("mis_instret", instret, 64'd5);
    send(5'd0, 0, 2'd0, 0, 3'd0, 64'h77, 64'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("x0_we", 64'(rf_we), 64'd0);
    cyc();
    @(negedge clk);
    chk("x0_instret", instret, 64'd6);
    // Halt for three cycles with B waiting
    send(5'd1, 0, 2'd0, 0, 3'd0, 64'hAAAA, 64'd0);
    cyc();
    send(5'd2, 0, 2'd0, 0, 3'd0, 64'hBBBB, 64'd0);
    halt = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_ready", 64'(in_ready), 64'd0);
      chk("halt_we", 64'(rf_we), 64'd0);
      chk("halt_rd", 64'(rf_rd), 64'd1);
      chk("halt_data", rf_wdata, 64'hAAAA);
      cyc();
    end
    halt = 0;
    @(negedge clk);
    chk("a_we", 64'(rf_we), 64'd1);
    chk("a_data", rf_wdata, 64'hAAAA);
    cyc();
    idle();
    @(negedge clk);
    chk("b_we", 64'(rf_we), 64'd1);
    chk("b_rd", 64'(rf_rd), 64'd2);
    chk("b_data", rf_wdata, 64'hBBBB);
    cyc();
    @(negedge clk);
    chk("halt_instret", instret, 64'd8);
    // Flush kills held entry and blocks capture
    send(5'd3, 0, 2'd0, 0, 3'd0, 64'hCCCC, 64'd0);
    cyc();
    send(5'd4, 0, 2'd0, 0, 3'd0, 64'hDDDD, 64'd0);
    flush = 1;
    @(negedge clk);
    chk("flush_we", 64'(rf_we), 64'd0);
    cyc();
    flush = 0;
    idle();
    @(negedge clk);
    chk("flush_after_we", 64'(rf_we), 64'd0);
    cyc();
    @(negedge clk);
    chk("flush_instret", instret, 64'd8);
    // Asynchronous reset with an entry held
    send(5'd10, 0, 2'd0, 0, 3'd0, 64'h55, 64'd0);
    cyc();
    idle();
    #2;
    reset = 0;
    #1;
    chk("arst_we", 64'(rf_we), 64'd0);
    chk("arst_instret", instret, 64'd0);
    cyc();
    reset = 1;
    @(negedge clk);
    chk("arst_ready", 64'(in_ready), 64'd1);
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc();
      reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      in_valid = ($urandom_range(0, 9) < 7);
      in_rd = 5'($urandom);
      in_rd_we = ($urandom_range(0, 7) != 0);
      in_is_load = $urandom_range(0, 1) == 1;
      in_size = 2'($urandom);
      in_unsigned = $urandom_range(0, 1) == 1;
      in_addr_lo = 3'($urandom);
      in_alu_result = {$urandom, $urandom};
      in_mem_rdata = {$urandom, $urandom};
      halt = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 99) < 8);
    end
    cyc();
    reset = 1; halt = 0; flush = 0;
    idle();
    cyc();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage that sits directly upstream of the 64-bit, 32-entry register file and drives its write port (we, rd, in). It holds one retiring instruction in a pipeline register, aligns and sign- or zero-extends load data, and suppresses writes to x0. It also flags misaligned loads, exposes a bypass copy of the pending write to decode, and counts retired instructions.

Parameters:
XLEN, 64, datapath width; supported value is 64 only.
RADDR_W, 5, register index width.
CNT_W, 64, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  stage can accept an instruction this cycle.
in_rd  in  RADDR_W  destination register.
in_rd_we  in  1  instruction writes rd.
in_is_load  in  1  result comes from in_mem_rdata, not in_alu_result.
in_size  in  2  load size: 0 = B, 1 = H, 2 = W, 3 = D.
in_unsigned  in  1  zero-extend the load (LBU/LHU/LWU).
in_addr_lo  in  3  low 3 bits of the load address.
in_alu_result  in  XLEN  non-load result.
in_mem_rdata  in  XLEN  raw aligned doubleword read from memory.
halt  in  1  hold the held instruction; no commit while high.
flush  in  1  kill the held instruction and block capture.
rf_we  out  1  write enable to the register file.
rf_rd  out  RADDR_W  write index.
rf_wdata  out  XLEN  write data.
fwd_valid  out  1  bypass valid; equals rf_we.
fwd_rd  out  RADDR_W  bypass index.
fwd_data  out  XLEN  bypass data.
misalign_err  out  1  one-cycle pulse: a misaligned load committed without a write.
instret  out  CNT_W  count of committed instructions.

Behaviour:
- State: valid_q plus registered copies of every in_* field except the handshake. One entry, no skid buffer.
- Reset (reset = 0, asynchronous): valid_q = 0, instret = 0, all held fields = 0. Consequently rf_we = 0, fwd_valid = 0, misalign_err = 0, rf_rd = 0, rf_wdata = 0.
- in_ready = !valid_q || !halt. This is combinational and does not depend on in_valid.
- commit = valid_q && !halt && !flush.
- Next-state priority at each rising edge is reset > flush > capture > hold/drain:
  - flush: valid_q <- 0 and no capture, even if in_valid && in_ready. The entry killed by flush does not commit and instret does not increment.
  - capture: if in_valid && in_ready, load all fields and set valid_q <- 1.
  - hold: if valid_q && halt, keep all fields.
  - drain: otherwise valid_q <- 0.
- Latency: an instruction accepted at edge N drives rf_* during cycle N..N+1. The register file samples it at edge N+1, so the write is one cycle after acceptance. Back-to-back acceptance sustains 1 instruction per cycle.
- misaligned = is_load_q && (addr_lo_q mod 2^size_q != 0). Size D needs 000, W needs x00, H needs xx0, B is always aligned.
- rf_we = commit && rd_we_q && (rd_q != 0) && !misaligned.
- rf_rd = rd_q; rf_wdata = result. Both are combinational from the held state.
- Load result:
  - shifted = mem_rdata_q >> (8 * addr_lo_q).
  - Take the low 8/16/32/64 bits of shifted according to size.
  - Zero-extend if unsigned_q, otherwise sign-extend from the field MSB.
  - in_unsigned is ignored for size D.
- Non-load result: alu_result_q unchanged.
- misalign_err = commit && misaligned. A misaligned load still increments instret (the trap is raised elsewhere).
- instret increments by 1 on every commit and wraps modulo 2^CNT_W.
- rd = 0 with rd_we = 1: the instruction commits and counts, but rf_we = 0.
- fwd_* mirror rf_we, rf_rd and rf_wdata exactly in the same cycle.

Decomposition:
- Shared package: typedef load_size_t (enum SZ_B, SZ_H, SZ_W, SZ_D); XLEN and RADDR_W constants; packed struct wb_req_t bundling the in_* payload fields so the upstream stage can pass a single port.
- One natural sub-module: load_align. It is purely combinational: inputs rdata, addr_lo, size and unsigned; outputs data and misaligned. It can be unit-tested exhaustively on addr_lo × size × unsigned.

Test Plan:
1. Reset low mid-run with valid_q = 1 → rf_we = 0, instret = 0 immediately (asynchronous); after release, in_ready = 1.
2. ALU op: rd = 5, rd_we = 1, alu = 0x1234 accepted at edge N → during the next cycle rf_we = 1, rf_rd = 5, rf_wdata = 0x1234, fwd_* identical; instret becomes 1.
3. Loads with mem_rdata = 0x8899AABBCCDDEEFF:
   - LB, addr_lo = 1, signed → 0xFFFFFFFFFFFFFFEE.
   - LHU, addr_lo = 6 → 0x8899.
   - LW, addr_lo = 4, signed → 0xFFFFFFFF8899AABB.
4. LH with addr_lo = 3 → rf_we = 0, misalign_err pulses for 1 cycle, instret increments; ALU op to rd = 0 → rf_we = 0, instret increments.
5. halt held 3 cycles with entry A valid and in_valid = 1 → in_ready = 0, rf_we = 0, A held unchanged; after halt drops, A commits next, then B follows with no gap.
6. flush together with in_valid = 1 while A is held → neither A nor the new instruction commits, instret unchanged, valid_q = 0 the next cycle.
